// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match referee.
package pong_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        SERVE     = 2'd1,
        GAME_OVER = 2'd2
    } match_state_t;

    localparam int FREEZE_SHORT_DEF = 8000;
    localparam int FREEZE_LONG_DEF  = 131071;

    // A point ends the match when the new score reaches the target and,
    // with win-by-two enabled, the lead is at least two. When both sides
    // were already pinned at the saturated score, the point decides it.
    function automatic logic is_win(input int new_score,
                                    input int opp_score,
                                    input int old_score,
                                    input int score_max,
                                    input int win_score,
                                    input int win_by_two);
        return (new_score >= win_score) &&
               ((win_by_two == 0) ||
                (new_score - opp_score >= 2) ||
                ((old_score == score_max) && (opp_score == score_max)));
    endfunction

endpackage

// File: rtl/freeze_timer.sv
// Pause countdown: loads a tick count, counts down, and flags the cycle
// on which the pause should end (count reaches 1, or skip while > 1).
module freeze_timer #(
    parameter int FREEZE_W = 17
) (
    input  logic                game_clk,
    input  logic                load,
    input  logic [FREEZE_W-1:0] load_val,
    input  logic                skip,
    output logic                expire,
    output logic                busy
);

    logic [FREEZE_W-1:0] cnt;

    assign expire = (cnt == FREEZE_W'(1)) || (skip && (cnt > FREEZE_W'(1)));
    assign busy   = (cnt != '0);

    // Countdown register: load wins, expiry clears, otherwise decrement.
    // NOTE: no reset branch here; the parent asserts load during its own
    // reset, which places the long pause into cnt on that same edge.
    always_ff @(posedge game_clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, so ordering between always_ff blocks is irrelevant.
        if (load) begin
            cnt <= load_val;
        end else if (expire) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt - FREEZE_W'(1);
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Match referee: scoring, serve direction, speed ramp and pause sequencing
// between the debounce logic and the ball engine.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int WIN_BY_TWO   = 0,
    parameter int FREEZE_W     = 17,
    parameter int FREEZE_SHORT = FREEZE_SHORT_DEF,
    parameter int FREEZE_LONG  = FREEZE_LONG_DEF,
    parameter int SPEED_W      = 4,
    parameter int MAX_SPEED    = 15
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SPEED_W-1:0] difficulty,
    input  logic               out_left,
    input  logic               out_right,
    input  logic               hit,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [SPEED_W-1:0] speed,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic               freeze_active,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;
    localparam logic [FREEZE_W-1:0] SHORT_V   = FREEZE_W'(FREEZE_SHORT);
    localparam logic [FREEZE_W-1:0] LONG_V    = FREEZE_W'(FREEZE_LONG);
    localparam logic [SPEED_W-1:0]  SPEED_CAP = SPEED_W'(MAX_SPEED);

    match_state_t        state, state_d;
    logic [SCORE_W-1:0]  p1_d, p2_d, new_score;
    logic [SPEED_W-1:0]  speed_d;
    logic                ball_reset_d, dir_d, winner_d;
    logic                won, won_d;
    logic                timer_load, timer_expire, timer_busy;
    logic [FREEZE_W-1:0] timer_load_val;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    freeze_timer #(
        .FREEZE_W (FREEZE_W)
    ) u_timer (
        .game_clk (game_clk),
        .load     (timer_load),
        .load_val (timer_load_val),
        .skip     (start),
        .expire   (timer_expire),
        .busy     (timer_busy)
    );

    assign freeze_active = (state != PLAY);
    assign game_over     = won && (state == GAME_OVER);

    // Next-state, score, speed and pause-load decisions for the coming edge.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d        = state;
        p1_d           = score_p1;
        p2_d           = score_p2;
        speed_d        = speed;
        dir_d          = serve_dir;
        winner_d       = winner;
        won_d          = won;
        ball_reset_d   = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = SHORT_V;
        new_score      = '0;

        unique case (state)
            SERVE, GAME_OVER: begin
                if (timer_busy && timer_expire) begin
                    state_d      = PLAY;
                    ball_reset_d = 1'b1;
                    speed_d      = difficulty;
                    if (state == GAME_OVER) begin
                        p1_d  = '0;
                        p2_d  = '0;
                        won_d = 1'b0;
                    end
                end
            end
            PLAY: begin
                if (out_left) begin
                    new_score  = sat_inc(score_p1);
                    p1_d       = new_score;
                    dir_d      = 1'b1;
                    speed_d    = '0;
                    timer_load = 1'b1;
                    if (is_win(int'(new_score), int'(score_p2), int'(score_p1),
                               int'(SCORE_MAX), WIN_SCORE, WIN_BY_TWO)) begin
                        state_d        = GAME_OVER;
                        timer_load_val = LONG_V;
                        winner_d       = 1'b0;
                        won_d          = 1'b1;
                    end else begin
                        state_d = SERVE;
                    end
                end else if (out_right) begin
                    new_score  = sat_inc(score_p2);
                    p2_d       = new_score;
                    dir_d      = 1'b0;
                    speed_d    = '0;
                    timer_load = 1'b1;
                    if (is_win(int'(new_score), int'(score_p1), int'(score_p2),
                               int'(SCORE_MAX), WIN_SCORE, WIN_BY_TWO)) begin
                        state_d        = GAME_OVER;
                        timer_load_val = LONG_V;
                        winner_d       = 1'b1;
                        won_d          = 1'b1;
                    end else begin
                        state_d = SERVE;
                    end
                end else if (hit) begin
                    speed_d = (speed >= SPEED_CAP) ? SPEED_CAP : speed + SPEED_W'(1);
                end
            end
            default: state_d = GAME_OVER;
        endcase

        if (reset) begin
            timer_load     = 1'b1;
            timer_load_val = LONG_V;
        end
    end

    // Registered state and outputs; reset parks the match in the long pause.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            state      <= GAME_OVER;
            score_p1   <= '0;
            score_p2   <= '0;
            speed      <= '0;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            winner     <= 1'b0;
            won        <= 1'b0;
        end else begin
            state      <= state_d;
            score_p1   <= p1_d;
            score_p2   <= p2_d;
            speed      <= speed_d;
            ball_reset <= ball_reset_d;
            serve_dir  <= dir_d;
            winner     <= winner_d;
            won        <= won_d;
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: three instances share stimulus (plain win,
// win-by-two, and win-by-two with a 2-bit saturating score) and are
// compared against a rule-level model of the referee.
module tb_match_ctrl;

    localparam int WIN   = 3;
    localparam int SHORT = 5;
    localparam int LONG  = 10;
    localparam int MAXSP = 6;
    localparam int N     = 3;

    // Reset image: {p1, p2, speed, ball_reset, serve_dir, freeze, game_over, winner}
    localparam logic [16:0] RST_V = {4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic       game_clk;
    logic       reset, start, out_left, out_right, hit;
    logic [3:0] difficulty;

    logic [3:0] p1_a, p2_a, p1_b, p2_b;
    logic [1:0] p1_c, p2_c;
    logic [3:0] spd [N];
    logic       br [N], dir [N], fa [N], go [N], win [N];

    int passed = 0;
    int total  = 0;

    // Rule-level model state, one slot per instance.
    int cfg_wb2  [N] = '{0, 1, 1};
    int cfg_smax [N] = '{15, 15, 3};
    int m_p1 [N], m_p2 [N], m_speed [N], m_br [N], m_dir [N];
    int m_win [N], m_go [N], m_frozen [N], m_over [N], m_cnt [N];

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    match_ctrl #(.SCORE_W(4), .WIN_SCORE(WIN), .WIN_BY_TWO(0), .FREEZE_W(17),
                 .FREEZE_SHORT(SHORT), .FREEZE_LONG(LONG), .SPEED_W(4), .MAX_SPEED(MAXSP))
    dut_a (.game_clk(game_clk), .reset(reset), .start(start), .difficulty(difficulty),
           .out_left(out_left), .out_right(out_right), .hit(hit),
           .score_p1(p1_a), .score_p2(p2_a), .speed(spd[0]), .ball_reset(br[0]),
           .serve_dir(dir[0]), .freeze_active(fa[0]), .game_over(go[0]), .winner(win[0]));

    match_ctrl #(.SCORE_W(4), .WIN_SCORE(WIN), .WIN_BY_TWO(1), .FREEZE_W(17),
                 .FREEZE_SHORT(SHORT), .FREEZE_LONG(LONG), .SPEED_W(4), .MAX_SPEED(MAXSP))
    dut_b (.game_clk(game_clk), .reset(reset), .start(start), .difficulty(difficulty),
           .out_left(out_left), .out_right(out_right), .hit(hit),
           .score_p1(p1_b), .score_p2(p2_b), .speed(spd[1]), .ball_reset(br[1]),
           .serve_dir(dir[1]), .freeze_active(fa[1]), .game_over(go[1]), .winner(win[1]));

    match_ctrl #(.SCORE_W(2), .WIN_SCORE(WIN), .WIN_BY_TWO(1), .FREEZE_W(17),
                 .FREEZE_SHORT(SHORT), .FREEZE_LONG(LONG), .SPEED_W(4), .MAX_SPEED(MAXSP))
    dut_c (.game_clk(game_clk), .reset(reset), .start(start), .difficulty(difficulty),
           .out_left(out_left), .out_right(out_right), .hit(hit),
           .score_p1(p1_c), .score_p2(p2_c), .speed(spd[2]), .ball_reset(br[2]),
           .serve_dir(dir[2]), .freeze_active(fa[2]), .game_over(go[2]), .winner(win[2]));

    function automatic logic [16:0] obs(input int i);
        logic [3:0] s1, s2;
        case (i)
            0:       begin s1 = p1_a;          s2 = p2_a;          end
            1:       begin s1 = p1_b;          s2 = p2_b;          end
            default: begin s1 = {2'b00, p1_c}; s2 = {2'b00, p2_c}; end
        endcase
        return {s1, s2, spd[i], br[i], dir[i], fa[i], go[i], win[i]};
    endfunction

    function automatic logic [16:0] exp_v(input int i);
        return {4'(m_p1[i]), 4'(m_p2[i]), 4'(m_speed[i]), 1'(m_br[i]), 1'(m_dir[i]),
                1'(m_frozen[i]), 1'(m_go[i]), 1'(m_win[i])};
    endfunction

    // A point for side (0 = p1, 1 = p2) under the referee's rules.
    task automatic model_point(input int i, input int side);
        int own, opp, s;
        own = side ? m_p2[i] : m_p1[i];
        opp = side ? m_p1[i] : m_p2[i];
        s   = (own + 1 > cfg_smax[i]) ? cfg_smax[i] : own + 1;
        if (side) m_p2[i] = s; else m_p1[i] = s;
        m_dir[i]    = side ? 0 : 1;
        m_speed[i]  = 0;
        m_frozen[i] = 1;
        if (s >= WIN && (cfg_wb2[i] == 0 || s - opp >= 2 ||
                         (own == cfg_smax[i] && opp == cfg_smax[i]))) begin
            m_over[i] = 1;
            m_go[i]   = 1;
            m_win[i]  = side;
            m_cnt[i]  = LONG;
        end else begin
            m_cnt[i] = SHORT;
        end
    endtask

    task automatic model_step(input int i);
        if (reset) begin
            m_p1[i] = 0; m_p2[i] = 0; m_speed[i] = 0; m_br[i] = 1; m_dir[i] = 0;
            m_win[i] = 0; m_go[i] = 0; m_frozen[i] = 1; m_over[i] = 1; m_cnt[i] = LONG;
        end else begin
            m_br[i] = 0;
            if (m_frozen[i] != 0) begin
                if (m_cnt[i] == 1 || (start && m_cnt[i] > 1)) begin
                    m_frozen[i] = 0;
                    m_br[i]     = 1;
                    m_speed[i]  = int'(difficulty);
                    if (m_over[i] != 0) begin
                        m_p1[i] = 0; m_p2[i] = 0; m_go[i] = 0; m_over[i] = 0;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end else if (out_left) begin
                model_point(i, 0);
            end else if (out_right) begin
                model_point(i, 1);
            end else if (hit) begin
                m_speed[i] = (m_speed[i] + 1 > MAXSP) ? MAXSP : m_speed[i] + 1;
            end
        end
    endtask

    // One clock: model advances on the edge, outputs settle by the falling edge.
    task automatic tick();
        @(posedge game_clk);
        for (int i = 0; i < N; i++) model_step(i);
        @(negedge game_clk);
    endtask

    task automatic score(input bit right);
        out_left  = !right;
        out_right = right;
        tick();
        out_left  = 1'b0;
        out_right = 1'b0;
    endtask

    task automatic serve();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (obs(i) !== RST_V)
                $display("FAIL reset_values inst%0d: got %h, expected %h", i, obs(i), RST_V);
            else passed++;
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if (fa[0] !== 1'b1 || br[0] !== 1'b0)
                $display("FAIL freeze_hold cycle%0d: freeze=%b ball_reset=%b, expected 1 0", k, fa[0], br[0]);
            else passed++;
        end
        tick();
        total++;
        if (br[0] !== 1'b1 || fa[0] !== 1'b0 || spd[0] !== 4'd4)
            $display("FAIL serve_release: br=%b freeze=%b speed=%0d, expected 1 0 4", br[0], fa[0], spd[0]);
        else passed++;
        tick();
        total++;
        if (br[0] !== 1'b0)
            $display("FAIL ball_reset_pulse: br=%b, expected 0", br[0]);
        else passed++;
    endtask

    task automatic test_hit_ramp();
        int exp_sp [3] = '{5, 6, 6};
        hit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                total++;
                if (spd[i] !== 4'(exp_sp[k]))
                    $display("FAIL hit_ramp inst%0d hit%0d: speed=%0d, expected %0d", i, k, spd[i], exp_sp[k]);
                else passed++;
            end
        end
        hit = 1'b0;
    endtask

    task automatic test_point();
        score(1'b0);
        total++;
        if (p1_a !== 4'd1 || spd[0] !== 4'd0 || dir[0] !== 1'b1 || fa[0] !== 1'b1 || go[0] !== 1'b0)
            $display("FAIL point_left: p1=%0d speed=%0d dir=%b freeze=%b go=%b, expected 1 0 1 1 0",
                     p1_a, spd[0], dir[0], fa[0], go[0]);
        else passed++;
        tick();
        tick();
        total++;
        if (fa[0] !== 1'b1 || br[0] !== 1'b0)
            $display("FAIL serve_wait: freeze=%b br=%b, expected 1 0", fa[0], br[0]);
        else passed++;
        serve();
        total++;
        if (br[0] !== 1'b1 || fa[0] !== 1'b0 || spd[0] !== 4'd4)
            $display("FAIL start_skip: br=%b freeze=%b speed=%0d, expected 1 0 4", br[0], fa[0], spd[0]);
        else passed++;
    endtask

    task automatic test_simultaneous();
        out_left  = 1'b1;
        out_right = 1'b1;
        tick();
        out_left  = 1'b0;
        out_right = 1'b0;
        total++;
        if (p1_a !== 4'd2 || p2_a !== 4'd0 || dir[0] !== 1'b1)
            $display("FAIL both_out: p1=%0d p2=%0d dir=%b, expected 2 0 1", p1_a, p2_a, dir[0]);
        else passed++;
        serve();
    endtask

    task automatic test_win();
        score(1'b0);
        for (int i = 0; i < N; i++) begin
            total++;
            if (go[i] !== 1'b1 || win[i] !== 1'b0 || fa[i] !== 1'b1)
                $display("FAIL win_3_0 inst%0d: go=%b winner=%b freeze=%b, expected 1 0 1", i, go[i], win[i], fa[i]);
            else passed++;
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++;
            if (go[0] !== 1'b1 || p1_a !== 4'd3)
                $display("FAIL game_over_hold cycle%0d: go=%b p1=%0d, expected 1 3", k, go[0], p1_a);
            else passed++;
        end
        tick();
        total++;
        if (p1_a !== 4'd0 || p2_a !== 4'd0 || br[0] !== 1'b1 || go[0] !== 1'b0 || p1_c !== 2'd0)
            $display("FAIL new_match: p1=%0d p2=%0d br=%b go=%b p1c=%0d, expected 0 0 1 0 0",
                     p1_a, p2_a, br[0], go[0], p1_c);
        else passed++;
    endtask

    task automatic test_win_by_two();
        score(1'b0); serve();
        score(1'b1); serve();
        score(1'b0); serve();
        score(1'b1); serve();
        total++;
        if (p1_b !== 4'd2 || p2_b !== 4'd2)
            $display("FAIL deuce: p1=%0d p2=%0d, expected 2 2", p1_b, p2_b);
        else passed++;
        score(1'b0);
        total++;
        if (go[1] !== 1'b0 || fa[1] !== 1'b1 || p1_b !== 4'd3)
            $display("FAIL wb2_3_2: go=%b freeze=%b p1=%0d, expected 0 1 3", go[1], fa[1], p1_b);
        else passed++;
        total++;
        if (go[0] !== 1'b1 || win[0] !== 1'b0)
            $display("FAIL plain_3_2: go=%b winner=%b, expected 1 0", go[0], win[0]);
        else passed++;
        serve();
        score(1'b0);
        total++;
        if (go[1] !== 1'b1 || win[1] !== 1'b0 || p1_b !== 4'd4)
            $display("FAIL wb2_4_2: go=%b winner=%b p1=%0d, expected 1 0 4", go[1], win[1], p1_b);
        else passed++;
        total++;
        if (go[2] !== 1'b0 || p1_c !== 2'd3)
            $display("FAIL sat_no_win: go=%b p1=%0d, expected 0 3", go[2], p1_c);
        else passed++;
        serve();
        score(1'b1);
        total++;
        if (go[2] !== 1'b0 || p2_c !== 2'd3)
            $display("FAIL sat_3_3: go=%b p2=%0d, expected 0 3", go[2], p2_c);
        else passed++;
        serve();
        score(1'b1);
        total++;
        if (go[2] !== 1'b1 || win[2] !== 1'b1 || p2_c !== 2'd3)
            $display("FAIL sat_decider: go=%b winner=%b p2=%0d, expected 1 1 3", go[2], win[2], p2_c);
        else passed++;
    endtask

    task automatic test_reset_mid_freeze();
        tick();
        reset     = 1'b1;
        out_left  = 1'b1;
        hit       = 1'b1;
        start     = 1'b1;
        tick();
        reset     = 1'b0;
        out_left  = 1'b0;
        hit       = 1'b0;
        start     = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (obs(i) !== RST_V)
                $display("FAIL reset_mid_freeze inst%0d: got %h, expected %h", i, obs(i), RST_V);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [16:0] mask;
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 499) == 0);
            start      = ($urandom_range(0, 15) == 0);
            out_left   = ($urandom_range(0, 11) == 0);
            out_right  = ($urandom_range(0, 11) == 0);
            hit        = ($urandom_range(0, 3) == 0);
            difficulty = 4'($urandom_range(0, 15));
            tick();
            for (int i = 0; i < N; i++) begin
                mask = (m_go[i] != 0) ? 17'h1ffff : 17'h1fffe;
                total++;
                if ((obs(i) & mask) !== (exp_v(i) & mask))
                    $display("FAIL random inst%0d cycle%0d: got %h, expected %h",
                             i, n, obs(i) & mask, exp_v(i) & mask);
                else passed++;
            end
        end
        reset = 1'b0; start = 1'b0; out_left = 1'b0; out_right = 1'b0; hit = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        out_left   = 1'b0;
        out_right  = 1'b0;
        hit        = 1'b0;
        difficulty = 4'd4;
        @(negedge game_clk);
        test_reset();
        test_hit_ramp();
        test_point();
        test_simultaneous();
        test_win();
        test_win_by_two();
        test_reset_mid_freeze();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
